// File: rtl/alux_unit.sv
// Multi-cycle ALU: single-cycle add/logic/shift ops, iterative shift-add multiply
// and restoring divide, returning a registered result with a one-cycle done pulse.
module alux_unit #(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         opr,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               alux_done,
    output logic               error
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SHL = 4'b0110,
        OP_MUL = 4'b1000,
        OP_DIV = 4'b1001,
        OP_MOD = 4'b1010
    } opcode_e;

    typedef enum logic {IDLE, EXEC} state_e;

    state_e             state_q;
    logic [3:0]         op_q;
    logic [2*WIDTH-1:0] a_q;      // multiplicand, shifted left once per MUL iteration
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;    // MUL: partial product; DIV/MOD: {remainder, quotient}
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] result_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;

    logic               is_mul;
    logic               is_div;
    logic               div_zero;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [2*WIDTH-1:0] short_res;
    logic               short_err;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] iter_res;

    assign is_mul   = (op_q == OP_MUL);
    assign is_div   = (op_q == OP_DIV) || (op_q == OP_MOD);
    assign div_zero = is_div && (b_q == '0);
    assign sum_w    = {1'b0, a_q[WIDTH-1:0]} + {1'b0, b_q};
    assign diff_w   = {1'b0, a_q[WIDTH-1:0]} - {1'b0, b_q};

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        short_res = '0;
        short_err = 1'b0;
        case (op_q)
            OP_ADD:  short_res = {{(WIDTH-1){1'b0}}, sum_w};
            OP_SUB:  short_res = {{(WIDTH-1){1'b0}}, diff_w};
            OP_AND:  short_res = {{WIDTH{1'b0}}, a_q[WIDTH-1:0] & b_q};
            OP_OR:   short_res = {{WIDTH{1'b0}}, a_q[WIDTH-1:0] | b_q};
            OP_XOR:  short_res = {{WIDTH{1'b0}}, a_q[WIDTH-1:0] ^ b_q};
            OP_SHL:  short_res = a_q << b_q[3:0];
            OP_MUL, OP_DIV, OP_MOD: short_res = '0;
            default: short_err = 1'b1;
        endcase
    end

    // Restoring divide step: shift the next dividend bit into the remainder, subtract if it fits.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign div_sub   = div_shift[WIDTH-1:0] - b_q;

    always_comb begin
        acc_d    = acc_q;
        iter_res = '0;
        if (is_mul) begin
            acc_d    = acc_q + (b_q[0] ? a_q : '0);
            iter_res = acc_d;
        end else begin
            acc_d = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
            if (op_q == OP_MOD) iter_res = {{WIDTH{1'b0}}, acc_d[2*WIDTH-1:WIDTH]};
            else                iter_res = {{WIDTH{1'b0}}, acc_d[WIDTH-1:0]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= opr;
                        a_q     <= {{WIDTH{1'b0}}, a};
                        b_q     <= b;
                        acc_q   <= (opr == OP_MUL) ? '0 : {{WIDTH{1'b0}}, a};
                        cnt_q   <= '0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if ((is_mul || is_div) && !div_zero) begin
                        acc_q <= acc_d;
                        if (is_mul) begin
                            a_q <= a_q << 1;
                            b_q <= b_q >> 1;
                        end
                        if (cnt_q == LAST) begin
                            cnt_q    <= '0;
                            result_q <= iter_res;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        result_q <= div_zero ? '1 : short_res;
                        error_q  <= div_zero | short_err;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result    = result_q;
    assign busy      = busy_q;
    assign alux_done = done_q;
    assign error     = error_q;
endmodule

// File: tb/tb_alux_unit.sv
// Self-checking bench for alux_unit: directed cases from the test plan plus
// randomized operations compared against an arithmetic reference model.
module tb_alux_unit;
    localparam int W  = 16;
    localparam int RW = 2 * W;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    opr   = '0;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic [RW-1:0] result;
    logic          busy;
    logic          alux_done;
    logic          error;

    int checks   = 0;
    int failures = 0;

    alux_unit #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .opr       (opr),
        .a         (a),
        .b         (b),
        .result    (result),
        .busy      (busy),
        .alux_done (alux_done),
        .error     (error)
    );

    always #5 clock = ~clock;

    // Reference model: result, error flag and completion latency in cycles after acceptance.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [RW-1:0] r, output logic e, output int lat);
        longint unsigned ux = 64'(x);
        longint unsigned uy = 64'(y);
        longint unsigned m  = 64'(1) << W;
        r = '0; e = 1'b0; lat = 1;
        case (op)
            4'h0: r = RW'(ux + uy);
            4'h1: r = RW'(((ux - uy) & (m - 1)) | ((ux < uy) ? m : 0));
            4'h2: r = RW'(ux & uy);
            4'h3: r = RW'(ux | uy);
            4'h4: r = RW'(ux ^ uy);
            4'h6: r = RW'(ux << (uy % 16));
            4'h8: begin r = RW'(ux * uy); lat = W; end
            4'h9, 4'hA: begin
                if (uy == 0) begin
                    r = '1; e = 1'b1;
                end else begin
                    r = RW'((op == 4'h9) ? ux / uy : ux % uy);
                    lat = W;
                end
            end
            default: e = 1'b1;
        endcase
    endfunction

    // Drives one request from an idle cycle and waits for alux_done; lat = -1 on timeout.
    // flow_ok is low if busy/alux_done misbehave between acceptance and completion.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit hold, output int lat, output logic [RW-1:0] r,
                         output logic e, output logic flow_ok, output logic acc_done);
        opr = op; a = x; b = y; start = 1'b1;
        @(posedge clock); #1;
        flow_ok  = (busy === 1'b1);
        acc_done = alux_done;
        if (!hold) start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (hold) begin
                opr = 4'($urandom); a = W'($urandom); b = W'($urandom);
            end
            @(posedge clock); #1;
            if (alux_done === 1'b1) begin
                lat = k;
                break;
            end
            if (busy !== 1'b1) flow_ok = 1'b0;
        end
        start = 1'b0;
        r = result;
        e = error;
        if (busy !== 1'b0) flow_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; opr = 4'b0000; a = W'($urandom); b = W'($urandom);
        repeat (2) begin
            @(posedge clock); #1;
            checks++;
            if ({result, busy, alux_done, error} !== '0) begin
                failures++;
                $display("FAIL reset_hold: got result=%h busy=%b done=%b err=%b, want all zero",
                         result, busy, alux_done, error);
            end
        end
        start = 1'b0; reset = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            checks++;
            if ({result, busy, alux_done, error} !== '0) begin
                failures++;
                $display("FAIL reset_release_idle: got result=%h busy=%b done=%b err=%b, want all zero",
                         result, busy, alux_done, error);
            end
        end
    endtask

    task automatic test_add_sub();
        int lat; logic [RW-1:0] r; logic e, fok, ad;
        issue(4'b0000, 16'hFFFF, 16'h0001, 1'b0, lat, r, e, fok, ad);
        checks++;
        if (lat !== 1 || r !== 32'h0001_0000 || e !== 1'b0 || fok !== 1'b1) begin
            failures++;
            $display("FAIL add_carry: got lat=%0d r=%h e=%b flow=%b, want lat=1 r=00010000 e=0 flow=1",
                     lat, r, e, fok);
        end
        checks++;
        if (alux_done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_in_done_cycle: got done=%b want 1", alux_done);
        end
        issue(4'b0001, 16'd3, 16'd5, 1'b0, lat, r, e, fok, ad);
        checks++;
        if (lat !== 1 || r !== 32'h0001_FFFE || e !== 1'b0 || fok !== 1'b1 || ad !== 1'b0) begin
            failures++;
            $display("FAIL b2b_sub_borrow: got lat=%0d r=%h e=%b flow=%b acc_done=%b, want lat=1 r=0001fffe e=0 flow=1 acc_done=0",
                     lat, r, e, fok, ad);
        end
    endtask

    task automatic test_mul();
        int lat; logic [RW-1:0] r; logic e, fok, ad;
        issue(4'b1000, 16'h1234, 16'h5678, 1'b1, lat, r, e, fok, ad);
        checks++;
        if (lat !== W || r !== 32'h0626_0060 || e !== 1'b0 || fok !== 1'b1) begin
            failures++;
            $display("FAIL mul_directed: got lat=%0d r=%h e=%b flow=%b, want lat=%0d r=06260060 e=0 flow=1",
                     lat, r, e, fok, W);
        end
        @(posedge clock); #1;
        checks++;
        if (alux_done !== 1'b0 || busy !== 1'b0 || result !== 32'h0626_0060) begin
            failures++;
            $display("FAIL mul_no_queue: got done=%b busy=%b r=%h, want done=0 busy=0 r=06260060",
                     alux_done, busy, result);
        end
    endtask

    task automatic test_div_mod();
        int lat; logic [RW-1:0] r; logic e, fok, ad;
        issue(4'b1001, 16'd100, 16'd7, 1'b0, lat, r, e, fok, ad);
        checks++;
        if (lat !== W || r !== 32'h0000_000E || e !== 1'b0 || fok !== 1'b1) begin
            failures++;
            $display("FAIL div_directed: got lat=%0d r=%h e=%b flow=%b, want lat=%0d r=0000000e e=0 flow=1",
                     lat, r, e, fok, W);
        end
        issue(4'b1010, 16'd100, 16'd7, 1'b0, lat, r, e, fok, ad);
        checks++;
        if (lat !== W || r !== 32'h0000_0002 || e !== 1'b0 || fok !== 1'b1) begin
            failures++;
            $display("FAIL mod_directed: got lat=%0d r=%h e=%b flow=%b, want lat=%0d r=00000002 e=0 flow=1",
                     lat, r, e, fok, W);
        end
    endtask

    task automatic test_errors();
        int lat; logic [RW-1:0] r; logic e, fok, ad;
        issue(4'b1001, 16'd1234, 16'd0, 1'b0, lat, r, e, fok, ad);
        checks++;
        if (lat !== 1 || r !== 32'hFFFF_FFFF || e !== 1'b1 || fok !== 1'b1) begin
            failures++;
            $display("FAIL div_by_zero: got lat=%0d r=%h e=%b flow=%b, want lat=1 r=ffffffff e=1 flow=1",
                     lat, r, e, fok);
        end
        @(posedge clock); #1;
        checks++;
        if (error !== 1'b1 || alux_done !== 1'b0 || result !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL error_held: got err=%b done=%b r=%h, want err=1 done=0 r=ffffffff",
                     error, alux_done, result);
        end
        issue(4'b1010, 16'd77, 16'd0, 1'b0, lat, r, e, fok, ad);
        checks++;
        if (lat !== 1 || r !== 32'hFFFF_FFFF || e !== 1'b1) begin
            failures++;
            $display("FAIL mod_by_zero: got lat=%0d r=%h e=%b, want lat=1 r=ffffffff e=1", lat, r, e);
        end
        issue(4'b0101, 16'h00FF, 16'h0F0F, 1'b0, lat, r, e, fok, ad);
        checks++;
        if (lat !== 1 || r !== 32'h0 || e !== 1'b1) begin
            failures++;
            $display("FAIL illegal_op: got lat=%0d r=%h e=%b, want lat=1 r=00000000 e=1", lat, r, e);
        end
        issue(4'b0000, 16'd1, 16'd2, 1'b0, lat, r, e, fok, ad);
        checks++;
        if (lat !== 1 || r !== 32'd3 || e !== 1'b0) begin
            failures++;
            $display("FAIL error_cleared: got lat=%0d r=%h e=%b, want lat=1 r=00000003 e=0", lat, r, e);
        end
    endtask

    task automatic test_random();
        int lat, exp_lat; logic [RW-1:0] r, exp_r; logic e, exp_e, fok, ad;
        logic [3:0] op; logic [W-1:0] x, y;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = W'($urandom);
            y  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            model(op, x, y, exp_r, exp_e, exp_lat);
            issue(op, x, y, 1'b0, lat, r, e, fok, ad);
            checks++;
            if (lat !== exp_lat || r !== exp_r || e !== exp_e || fok !== 1'b1) begin
                failures++;
                $display("FAIL random[%0d] op=%b a=%h b=%h: got lat=%0d r=%h e=%b flow=%b, want lat=%0d r=%h e=%b flow=1",
                         i, op, x, y, lat, r, e, fok, exp_lat, exp_r, exp_e);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int dones = 0;
        opr = 4'b1000; a = 16'hABCD; b = 16'h1357; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
            if (alux_done === 1'b1) dones++;
        end
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        checks++;
        if (busy !== 1'b0 || result !== '0 || alux_done !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_op_state: got busy=%b r=%h done=%b err=%b, want all zero",
                     busy, result, alux_done, error);
        end
        repeat (20) begin
            @(posedge clock); #1;
            if (alux_done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_op_no_done: got %0d done pulses busy=%b, want 0 pulses busy=0",
                     dones, busy);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div_mod();
        test_errors();
        test_random();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
